// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response handshake bundle between the pipeline and the execute-stage ALU.
interface alu_exec_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       alu_ctl;
    logic             sign;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_overflow;
    modport master (
        output flush, in_valid, alu_ctl, sign, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_overflow
    );
    modport slave (
        input  flush, in_valid, alu_ctl, sign, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_overflow
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU; single-cycle logic/arithmetic, 1-bit-per-cycle iterative shifts.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic       clk,
    input logic       reset_n,
    alu_exec_if.slave bus
);
    localparam logic [4:0] OP_AND = 5'b00000, OP_OR  = 5'b00001, OP_SUB = 5'b00110, OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01100, OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SLL = 5'b10000, OP_SRL = 5'b11000, OP_SRA = 5'b11001;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] acc_q, result_q, res_d, acc_d, sum, diff;
    logic [SHW-1:0]   cnt_q, amt;
    logic [1:0]       sh_q;
    logic             valid_q, zero_q, ovf_q, ovf_d, lt, is_shift, accept;
    assign amt      = bus.in_a[SHW-1:0];
    assign is_shift = bus.alu_ctl inside {OP_SLL, OP_SRL, OP_SRA};
    assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready && !bus.flush;
    // sh_q[1] selects right shift, sh_q[0] selects arithmetic fill
    assign acc_d = sh_q[1] ? {sh_q[0] & acc_q[WIDTH-1], acc_q[WIDTH-1:1]} : {acc_q[WIDTH-2:0], 1'b0};
    always_comb begin
        sum   = bus.in_a + bus.in_b;
        diff  = bus.in_a - bus.in_b;
        lt    = bus.sign ? ($signed(bus.in_a) < $signed(bus.in_b)) : (bus.in_a < bus.in_b);
        res_d = sum;
        ovf_d = 1'b0;
        case (bus.alu_ctl)
            OP_AND: res_d = bus.in_a & bus.in_b;
            OP_OR:  res_d = bus.in_a | bus.in_b;
            OP_NOR: res_d = ~(bus.in_a | bus.in_b);
            OP_XOR: res_d = bus.in_a ^ bus.in_b;
            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, lt};
            OP_SUB: begin
                res_d = diff;
                ovf_d = bus.sign & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]) & (diff[WIDTH-1] ^ bus.in_a[WIDTH-1]);
            end
            OP_SLL, OP_SRL, OP_SRA: res_d = bus.in_b;
            default: ovf_d = bus.sign & ~(bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]) & (sum[WIDTH-1] ^ bus.in_a[WIDTH-1]);
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
        end else if (bus.flush) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            if (is_shift && amt != '0) begin
                state_q <= SHIFT;
                valid_q <= 1'b0;
                acc_q   <= bus.in_b;
                cnt_q   <= amt;
                sh_q    <= {bus.alu_ctl[3], bus.alu_ctl[0]};
            end else begin
                state_q  <= DONE;
                valid_q  <= 1'b1;
                result_q <= res_d;
                zero_q   <= (res_d == '0);
                ovf_q    <= ovf_d;
            end
        end else if (state_q == SHIFT) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) begin
                state_q  <= DONE;
                valid_q  <= 1'b1;
                result_q <= acc_d;
                zero_q   <= (acc_d == '0);
                ovf_q    <= 1'b0;
            end
        end else if (state_q == DONE && bus.out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end
    end
    assign bus.out_valid    = valid_q;
    assign bus.out_result   = result_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_overflow = ovf_q;
endmodule
